// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word reads to IM and buffers
// returned words in a prefetch FIFO for decode. Optional counters under IF_PERF_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fetch_en,
  input  logic        pc_W_PC,
  input  logic [31:0] pc_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            drop_q, drop_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]     mem_instr [DEPTH];
  logic [31:0]     mem_pc    [DEPTH];

  logic ack, push, pop, issue, start, head_valid;

  assign head_valid = (count_q != '0);
  assign ack        = (state_q == StReq) && im_ack;
  // An ack in the redirect cycle belongs to the old stream and is discarded.
  assign push       = ack && !drop_q && !pc_W_PC;
  assign pop        = head_valid && id_ready;
  // Credit check counts the word being pushed this edge so back-to-back issue stays safe.
  assign issue      = fetch_en && !pc_W_PC && ((32'(count_q) + 32'(push)) < DEPTH);
  assign start      = issue && ((state_q == StIdle) || im_ack);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StReq;
      StReq:   if (im_ack) state_d = issue ? StReq : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    im_req         = (state_q == StReq);
    im_addr        = addr_q;
    id_valid       = head_valid;
    id_instruction = head_valid ? mem_instr[rd_ptr_q] : '0;
    id_pc          = head_valid ? mem_pc[rd_ptr_q] : '0;
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_W_PC) begin
      pc_d = pc_target;
    end else if (push) begin
      pc_d = pc_q + PC_INC;
    end

    addr_d = start ? pc_d : addr_q;

    drop_d = drop_q;
    if (ack) begin
      drop_d = 1'b0;
    end else if (pc_W_PC && (state_q == StReq)) begin
      drop_d = 1'b1;
    end

    if (pc_W_PC) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      drop_q   <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      if (pc_W_PC) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= im_rdata;
      mem_pc[wr_ptr_q]    <= addr_q;
    end
  end

  no_push_when_full: assert property (@(posedge CLK) disable iff (!RESET)
    !(push && (count_q == CntW'(DEPTH))));

`ifdef IF_PERF_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != '1))    perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (pc_W_PC && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order fetch, credit stall, redirect with drop,
// same-cycle redirect/ack, PC wrap and asynchronous reset mid-request.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en, pc_W_PC, im_ack, id_ready;
  logic [31:0] pc_target, im_rdata;
  logic        im_req, id_valid;
  logic [31:0] im_addr, id_instruction, id_pc;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          auto_ack = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] ack_q[$];
  logic [31:0] hs_pc_q[$];
  logic [31:0] hs_ins_q[$];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .fetch_en       (fetch_en),
    .pc_W_PC        (pc_W_PC),
    .pc_target      (pc_target),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  // IM model: one idle cycle after req is seen, then ack with A000_0000 | addr.
  always begin
    @(posedge clk);
    #2;
    if (!auto_ack) begin
      wait_cnt = 0;
    end else if (im_req) begin
      if (wait_cnt >= 1) begin
        im_ack   = 1'b1;
        im_rdata = 32'hA000_0000 | im_addr;
        wait_cnt = 0;
      end else begin
        im_ack   = 1'b0;
        wait_cnt = 1;
      end
    end else begin
      im_ack   = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && im_req && im_ack) ack_q.push_back(im_addr);
    if (rst_n && id_valid && id_ready) begin
      hs_pc_q.push_back(id_pc);
      hs_ins_q.push_back(id_instruction);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    ack_q.delete();
    hs_pc_q.delete();
    hs_ins_q.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fetch_en  = 1'b0;
    pc_W_PC   = 1'b0;
    pc_target = '0;
    im_ack    = 1'b0;
    im_rdata  = '0;
    id_ready  = 1'b0;
    auto_ack  = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic wait_hs(input string tag, input int n, input int budget);
    int k = 0;
    while (hs_pc_q.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(hs_pc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int k = 0;
    while (!im_req && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(im_req), 32'd1);
  endtask

  function automatic logic [31:0] hs_pc(input int i);
    return (hs_pc_q.size() > i) ? hs_pc_q[i] : 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] hs_ins(input int i);
    return (hs_ins_q.size() > i) ? hs_ins_q[i] : 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] ack_at(input int i);
    return (ack_q.size() > i) ? ack_q[i] : 32'hDEAD_0000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    rst_n = 1'b0; fetch_en = 1'b0; pc_W_PC = 1'b0; pc_target = '0;
    im_ack = 1'b0; im_rdata = '0; id_ready = 1'b0;
    #3;
    check_eq("rst_im_req",   32'(im_req), 32'd0);
    check_eq("rst_im_addr",  im_addr, 32'h0);
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("rst_id_instr", id_instruction, 32'h0);
    check_eq("rst_id_pc",    id_pc, 32'h0);

    // In-order fetch, first id_valid 3 edges after release
    do_reset();
    fetch_en = 1'b1; id_ready = 1'b1; auto_ack = 1'b1;
    cyc(1);
    check_eq("t1_req_e1",    32'(im_req), 32'd1);
    check_eq("t1_valid_e1",  32'(id_valid), 32'd0);
    cyc(1);
    check_eq("t1_valid_e2",  32'(id_valid), 32'd0);
    cyc(1);
    check_eq("t1_valid_e3",  32'(id_valid), 32'd1);
    check_eq("t1_pc_e3",     id_pc, 32'h0);
    check_eq("t1_instr_e3",  id_instruction, 32'hA000_0000);
    wait_hs("t1_wait", 4, 40);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_pc%0d", i),    hs_pc(i),  32'(i));
      check_eq($sformatf("t1_instr%0d", i), hs_ins(i), 32'hA000_0000 | 32'(i));
    end

    // Credit stall: exactly DEPTH acks, then one pop buys one request at addr 4
    do_reset();
    fetch_en = 1'b1; auto_ack = 1'b1;
    cyc(20);
    check_eq("t2_acks",      32'(ack_q.size()), 32'd4);
    check_eq("t2_req_idle",  32'(im_req), 32'd0);
    check_eq("t2_head_pc",   id_pc, 32'h0);
    id_ready = 1'b1;
    cyc(1);
    id_ready = 1'b0;
    cyc(10);
    check_eq("t2_acks_after", 32'(ack_q.size()), 32'd5);
    check_eq("t2_addr4",      ack_at(4), 32'h4);
    check_eq("t2_req_idle2",  32'(im_req), 32'd0);
    check_eq("t2_head_pc2",   id_pc, 32'h1);

    // Redirect while the request to addr 5 waits for ack
    auto_ack = 1'b0; im_ack = 1'b0; id_ready = 1'b1;
    cyc(1);
    id_ready = 1'b0;
    wait_req("t3_wait_req", 10);
    check_eq("t3_addr5", im_addr, 32'h5);
    cyc(1);
    pc_W_PC = 1'b1; pc_target = 32'h0000_0100;
    cyc(1);
    pc_W_PC = 1'b0;
    check_eq("t3_hold_req",   32'(im_req), 32'd1);
    check_eq("t3_hold_addr",  im_addr, 32'h5);
    check_eq("t3_flushed",    32'(id_valid), 32'd0);
    cyc(1);
    check_eq("t3_hold_addr2", im_addr, 32'h5);
    clear_q();
    im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
    cyc(1);
    im_ack = 1'b0;
    check_eq("t3_dropped",    32'(id_valid), 32'd0);
    check_eq("t3_next_req",   32'(im_req), 32'd1);
    check_eq("t3_next_addr",  im_addr, 32'h100);
    auto_ack = 1'b1; id_ready = 1'b1;
    wait_hs("t3_wait_hs", 1, 20);
    check_eq("t3_first_pc",   hs_pc(0), 32'h100);
    check_eq("t3_first_ins",  hs_ins(0), 32'hA000_0100);
    check_eq("t3_drop_addr",  ack_at(0), 32'h5);

    // Redirect and ack in the same cycle
    auto_ack = 1'b0; im_ack = 1'b0; id_ready = 1'b0;
    wait_req("t4_wait_req", 10);
    im_ack = 1'b1; im_rdata = 32'hBAD0_BAD0; pc_W_PC = 1'b1; pc_target = 32'h0000_0200;
    cyc(1);
    im_ack = 1'b0; pc_W_PC = 1'b0;
    check_eq("t4_empty",     32'(id_valid), 32'd0);
    check_eq("t4_no_req",    32'(im_req), 32'd0);
    cyc(1);
    check_eq("t4_req",       32'(im_req), 32'd1);
    check_eq("t4_addr",      im_addr, 32'h200);

    // PC wraps from all-ones to zero
    do_reset();
    pc_W_PC = 1'b1; pc_target = 32'hFFFF_FFFF; auto_ack = 1'b1; id_ready = 1'b1;
    cyc(1);
    pc_W_PC = 1'b0; fetch_en = 1'b1;
    wait_hs("t5_wait_hs", 2, 30);
    check_eq("t5_pc0",  hs_pc(0),  32'hFFFF_FFFF);
    check_eq("t5_ins0", hs_ins(0), 32'hFFFF_FFFF);
    check_eq("t5_pc1",  hs_pc(1),  32'h0000_0000);
    check_eq("t5_ins1", hs_ins(1), 32'hA000_0000);

    // Asynchronous reset mid-request with a loaded FIFO
    do_reset();
    fetch_en = 1'b1; auto_ack = 1'b1;
    cyc(20);
    check_eq("t6_full_valid", 32'(id_valid), 32'd1);
    auto_ack = 1'b0; im_ack = 1'b0; id_ready = 1'b1;
    cyc(1);
    id_ready = 1'b0;
    wait_req("t6_wait_req", 10);
    check_eq("t6_addr4", im_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_req",   32'(im_req), 32'd0);
    check_eq("t6_async_valid", 32'(id_valid), 32'd0);
    check_eq("t6_async_addr",  im_addr, 32'h0);
    check_eq("t6_async_pc",    id_pc, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    clear_q();
    auto_ack = 1'b1; id_ready = 1'b1;
    wait_hs("t6_wait_hs", 1, 20);
    check_eq("t6_restart_pc", hs_pc(0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
